// File: rtl/mul_seq_unit.sv
// RV32M multiply group: decodes funct3 and runs MUL/MULH/MULHSU/MULHU on a
// shift-add datapath retiring BITS_PER_CYCLE multiplier bits per clock.
module mul_seq_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            mul_ext_valid,
    output logic            busy,
    output logic            mul_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int unsigned ACC_W  = 2 * XLEN;
    localparam int unsigned CYCLES = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = $clog2(CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mcand;
    logic [XLEN-1:0]  mplier;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic             hi_sel;

    logic             signed_a_c;
    logic             signed_b_c;
    logic             sign_a_c;
    logic             sign_b_c;
    logic [XLEN-1:0]  mag_a_c;
    logic [XLEN-1:0]  mag_b_c;
    logic [ACC_W-1:0] pp_c;
    logic [ACC_W-1:0] product_c;

    // Operand signedness and magnitudes; the most-negative value maps to 2^(XLEN-1).
    always_comb begin
        signed_a_c = (funct3 == 3'b001) || (funct3 == 3'b010);
        signed_b_c = (funct3 == 3'b001);
        sign_a_c   = signed_a_c & op_a[XLEN-1];
        sign_b_c   = signed_b_c & op_b[XLEN-1];
        mag_a_c    = sign_a_c ? (~op_a + XLEN'(1)) : op_a;
        mag_b_c    = sign_b_c ? (~op_b + XLEN'(1)) : op_b;
    end

    // mcand already carries the per-cycle left shift, so the partial product
    // only needs the low multiplier digit.
    always_comb begin
        pp_c      = mcand * ACC_W'(mplier[BITS_PER_CYCLE-1:0]);
        product_c = neg ? (~acc + ACC_W'(1)) : acc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mul_ext_valid && !funct3[2]) state_nxt = S_CALC;
            S_CALC:  if (cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; CALC spends one extra cycle at cnt == 0
    // to form the signed product so the result lands together with mul_ready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy      <= 1'b0;
            mul_ready <= 1'b0;
            illegal   <= 1'b0;
            result    <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            hi_sel    <= 1'b0;
        end else begin
            mul_ready <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mul_ext_valid) begin
                        if (funct3[2]) begin
                            illegal <= 1'b1;
                        end else begin
                            mcand  <= ACC_W'(mag_a_c);
                            mplier <= mag_b_c;
                            neg    <= sign_a_c ^ sign_b_c;
                            hi_sel <= (funct3[1:0] != 2'b00);
                            acc    <= '0;
                            cnt    <= CNT_W'(CYCLES);
                            busy   <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt == '0) begin
                        result    <= hi_sel ? product_c[ACC_W-1:XLEN] : product_c[XLEN-1:0];
                        mul_ready <= 1'b1;
                    end else begin
                        acc    <= acc + pp_c;
                        mcand  <= mcand << BITS_PER_CYCLE;
                        mplier <= mplier >> BITS_PER_CYCLE;
                        cnt    <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Scoreboard bench for mul_seq_unit: BITS_PER_CYCLE = 1 and 4 instances run
// side by side against a wide-arithmetic reference model.
module tb_mul_seq_unit;

    typedef struct packed {
        int          kind;  // 0 = mul_ready, 1 = illegal pulse, 2 = idle/busy snapshot
        logic [31:0] val;
        int          due;
        logic        busy;
    } sb_t;

    logic        clk;
    logic        resetn    [2];
    logic [2:0]  funct3_w  [2];
    logic [31:0] op_a_w    [2];
    logic [31:0] op_b_w    [2];
    logic        valid_w   [2];
    logic        busy_w    [2];
    logic        ready_w   [2];
    logic [31:0] result_w  [2];
    logic        illegal_w [2];

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_res [2];
    sb_t         sbq [2][$];

    mul_seq_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .resetn(resetn[0]), .funct3(funct3_w[0]), .op_a(op_a_w[0]),
        .op_b(op_b_w[0]), .mul_ext_valid(valid_w[0]), .busy(busy_w[0]),
        .mul_ready(ready_w[0]), .result(result_w[0]), .illegal(illegal_w[0])
    );

    mul_seq_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .resetn(resetn[1]), .funct3(funct3_w[1]), .op_a(op_a_w[1]),
        .op_b(op_b_w[1]), .mul_ext_valid(valid_w[1]), .busy(busy_w[1]),
        .mul_ready(ready_w[1]), .result(result_w[1]), .illegal(illegal_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-width signed product of sign/zero-extended operands.
    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [65:0]  sa;
        logic signed [65:0]  sb;
        logic signed [131:0] p;
        logic [131:0]        pu;
        sa = (f == 3'd1 || f == 3'd2) ? {{34{a[31]}}, a} : {34'd0, a};
        sb = (f == 3'd1) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = sa * sb;
        pu = p;
        return (f == 3'd0) ? pu[31:0] : pu[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    function automatic void push(input int g, input int k, input logic [31:0] v,
                                 input int due, input logic b);
        sb_t it;
        it.kind = k;
        it.val  = v;
        it.due  = due;
        it.busy = b;
        sbq[g].push_back(it);
    endfunction

    function automatic void chk(input int g, input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL g%0d %s: got %h want %h (cycle %0d)", g, nm, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard whenever a DUT pulses or a snapshot falls due.
    task automatic mon(input int g);
        sb_t it;
        if (sbq[g].size() > 0 && sbq[g][0].kind == 2 && cyc >= sbq[g][0].due) begin
            it = sbq[g].pop_front();
            chk(g, "snap_busy", 32'(busy_w[g]), 32'(it.busy));
            chk(g, "snap_result", result_w[g], it.val);
        end
        if (ready_w[g] || illegal_w[g]) begin
            if (sbq[g].size() == 0 || sbq[g][0].kind == 2) begin
                n_cmp++;
                n_bad++;
                $display("FAIL g%0d unexpected_pulse: got ready=%b illegal=%b want none (cycle %0d)",
                         g, ready_w[g], illegal_w[g], cyc);
            end else begin
                it = sbq[g].pop_front();
                chk(g, "ready", 32'(ready_w[g]), 32'(it.kind == 0));
                chk(g, "illegal", 32'(illegal_w[g]), 32'(it.kind == 1));
                chk(g, "result", result_w[g], it.val);
                chk(g, "latency_cycle", 32'(cyc), 32'(it.due));
                chk(g, "busy_at_pulse", 32'(busy_w[g]), 32'(it.kind == 0));
            end
        end else if (sbq[g].size() > 0 && sbq[g][0].kind != 2 && cyc > sbq[g][0].due) begin
            it = sbq[g].pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL g%0d timeout: got no pulse by cycle %0d want kind %0d at cycle %0d",
                     g, cyc, it.kind, it.due);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // One request; poke drives stray valids through CALC and DONE that must be ignored.
    task automatic op(input int g, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input bit poke);
        int n;
        int acc_cyc;
        n = (g == 0) ? 32 : 8;
        @(posedge clk); #1;
        funct3_w[g] = f3;
        op_a_w[g]   = a;
        op_b_w[g]   = b;
        valid_w[g]  = 1'b1;
        acc_cyc     = cyc + 1;
        if (f3[2]) begin
            push(g, 1, model_res[g], acc_cyc, 1'b0);
            push(g, 2, model_res[g], acc_cyc + 1, 1'b0);
        end else begin
            push(g, 2, model_res[g], acc_cyc + 1, 1'b1);
            push(g, 0, exp, acc_cyc + n + 1, 1'b1);
            push(g, 2, exp, acc_cyc + n + 2, 1'b0);
            model_res[g] = exp;
        end
        @(posedge clk); #1;
        valid_w[g]  = 1'b0;
        op_a_w[g]   = $urandom;
        op_b_w[g]   = $urandom;
        funct3_w[g] = 3'($urandom_range(0, 7));
        if (!f3[2]) begin
            repeat (n + 1) begin
                @(posedge clk); #1;
                valid_w[g]  = poke && ($urandom_range(0, 3) == 0);
                funct3_w[g] = 3'($urandom_range(0, 7));
            end
        end
    endtask

    task automatic idle(input int g, input int k);
        repeat (k) begin
            @(posedge clk); #1;
            valid_w[g] = 1'b0;
        end
    endtask

    // Start a MUL, then pull reset around CALC cycle 10.
    task automatic rst_mid(input int g);
        @(posedge clk); #1;
        funct3_w[g] = 3'b000;
        op_a_w[g]   = $urandom;
        op_b_w[g]   = $urandom;
        valid_w[g]  = 1'b1;
        @(posedge clk); #1;
        valid_w[g] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        sbq[g].delete();
        resetn[g]    = 1'b0;
        model_res[g] = 32'h0;
        push(g, 2, 32'h0, cyc, 1'b0);
        @(posedge clk); #1;
        resetn[g] = 1'b1;
    endtask

    task automatic drv(input int g);
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        if (g == 0) begin
            op(0, 3'b000, 32'd7, 32'd6, 32'h0000_002A, 1'b0);
            op(0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
            op(0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
            op(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
            op(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
            op(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
            op(0, 3'b100, 32'd12, 32'd34, 32'h0, 1'b0);
            idle(0, 2);
            op(0, 3'b011, 32'h0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
            op(0, 3'b000, 32'd9, 32'd11, 32'd99, 1'b1);
            rst_mid(0);
            op(0, 3'b000, 32'd3, 32'd5, 32'h0000_000F, 1'b0);
        end else begin
            op(1, 3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 32'hF8CC_93D6, 1'b0);
            op(1, 3'b111, 32'd1, 32'd1, 32'h0, 1'b0);
            rst_mid(1);
        end
        for (int i = 0; i < 1000; i++) begin
            f3 = ($urandom_range(0, 15) == 0) ? 3'(4 + $urandom_range(0, 3))
                                              : 3'($urandom_range(0, 3));
            a = pick();
            b = pick();
            op(g, f3, a, b, ref_mul(f3, a, b), $urandom_range(0, 3) == 0);
            idle(g, $urandom_range(0, 2));
        end
        @(posedge clk); #1;
        valid_w[g] = 1'b0;
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            resetn[g]    = 1'b0;
            valid_w[g]   = 1'b0;
            funct3_w[g]  = 3'b000;
            op_a_w[g]    = 32'h0;
            op_b_w[g]    = 32'h0;
            model_res[g] = 32'h0;
            push(g, 2, 32'h0, 0, 1'b0);
        end
        #12;
        resetn[0] = 1'b1;
        resetn[1] = 1'b1;
        fork
            drv(0);
            drv(1);
        join
        repeat (6) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
